// File: rtl/gshare_predictor_if.sv
// Fetch/resolve port bundle for the gshare predictor.
// The front end (master) drives requests and resolutions; the predictor (slave) answers.
interface gshare_predictor_if #(
    parameter int HIST_W = 12,
    parameter int PC_W   = 32
);
    logic              Fetch_Valid;
    logic [PC_W-1:0]   Fetch_PC;
    logic              Pred;
    logic [HIST_W-1:0] Pred_Idx;
    logic              Res_Valid;
    logic              Res_Taken;
    logic [HIST_W-1:0] Res_Idx;
    logic              Res_Mispredict;
    logic [HIST_W-1:0] Spec_Hist;

    modport master (
        output Fetch_Valid, Fetch_PC, Res_Valid, Res_Taken, Res_Idx, Res_Mispredict,
        input  Pred, Pred_Idx, Spec_Hist
    );

    modport slave (
        input  Fetch_Valid, Fetch_PC, Res_Valid, Res_Taken, Res_Idx, Res_Mispredict,
        output Pred, Pred_Idx, Spec_Hist
    );
endinterface

// File: rtl/gshare_predictor.sv
// Global-history (gshare) branch predictor: zero-latency PHT lookup with speculative
// history, architectural history for mispredict repair, saturating counter training.
module gshare_predictor #(
    parameter int HIST_W   = 12,
    parameter int CTR_W    = 2,
    parameter int PC_W     = 32,
    parameter bit XOR_MODE = 1'b1
) (
    input  logic               CLK,
    input  logic               RESET,
    gshare_predictor_if.slave  bp
);
    localparam int               DEPTH    = 2 ** HIST_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(2 ** (CTR_W - 1) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};

    logic [HIST_W-1:0] spec_hist_q, spec_hist_d;
    logic [HIST_W-1:0] arch_hist_q, arch_hist_d;
    logic [CTR_W-1:0]  pht_q [DEPTH];
    logic [CTR_W-1:0]  pht_d [DEPTH];

    logic [HIST_W-1:0] pc_bits;
    logic [HIST_W-1:0] idx;
    logic              pred;
    logic              unused_pc;

    // Word-aligned PC bits; the two byte-offset bits never distinguish branches.
    assign pc_bits   = bp.Fetch_PC[HIST_W+1:2];
    assign unused_pc = ^bp.Fetch_PC;

    always_comb begin
        idx  = XOR_MODE ? (spec_hist_q ^ pc_bits) : spec_hist_q;
        pred = pht_q[idx][CTR_W-1];

        // A mispredict squashes the same-cycle fetch, so repair wins over the fetch shift.
        spec_hist_d = spec_hist_q;
        if (bp.Res_Valid && bp.Res_Mispredict) begin
            spec_hist_d = {bp.Res_Taken, arch_hist_q[HIST_W-1:1]};
        end else if (bp.Fetch_Valid) begin
            spec_hist_d = {pred, spec_hist_q[HIST_W-1:1]};
        end

        arch_hist_d = arch_hist_q;
        if (bp.Res_Valid) begin
            arch_hist_d = {bp.Res_Taken, arch_hist_q[HIST_W-1:1]};
        end
    end

    always_comb begin
        pht_d = pht_q;
        if (bp.Res_Valid) begin
            if (bp.Res_Taken && (pht_q[bp.Res_Idx] != CTR_MAX)) begin
                pht_d[bp.Res_Idx] = pht_q[bp.Res_Idx] + CTR_W'(1);
            end else if (!bp.Res_Taken && (pht_q[bp.Res_Idx] != '0)) begin
                pht_d[bp.Res_Idx] = pht_q[bp.Res_Idx] - CTR_W'(1);
            end
        end
    end

    // NOTE: the PHT is register-based, so every entry takes the async reset; a BRAM
    // table could not be cleared in zero time and could not be read combinationally.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            spec_hist_q <= '0;
            arch_hist_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pht_q[i] <= CTR_INIT;
            end
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values computed above.
            spec_hist_q <= spec_hist_d;
            arch_hist_q <= arch_hist_d;
            pht_q       <= pht_d;
        end
    end

    assign bp.Pred      = pred;
    assign bp.Pred_Idx  = idx;
    assign bp.Spec_Hist = spec_hist_q;
endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: an integer-arithmetic reference model checked every
// cycle on two configurations, plus hand-computed literal expectations.
module tb_gshare_predictor;
    localparam int AH = 12;
    localparam int AC = 2;
    localparam int BH = 4;
    localparam int BC = 3;

    logic CLK = 1'b0;
    logic rst_a;
    logic rst_b;
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    always #5 CLK = ~CLK;

    gshare_predictor_if #(.HIST_W(AH), .PC_W(32)) a_if ();
    gshare_predictor_if #(.HIST_W(BH), .PC_W(32)) b_if ();

    gshare_predictor #(.HIST_W(AH), .CTR_W(AC), .PC_W(32), .XOR_MODE(1'b1)) dut_a (
        .CLK   (CLK),
        .RESET (rst_a),
        .bp    (a_if.slave)
    );

    gshare_predictor #(.HIST_W(BH), .CTR_W(BC), .PC_W(32), .XOR_MODE(1'b0)) dut_b (
        .CLK   (CLK),
        .RESET (rst_b),
        .bp    (b_if.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // ---------------- reference model (plain integers) ----------------
    int a_pht [1 << AH];
    int a_spec, a_arch;
    int b_pht [1 << BH];
    int b_spec, b_arch;

    function automatic int shift_in(input int old, input int b, input int w);
        return (b << (w - 1)) | (old >> 1);
    endfunction

    function automatic int train(input int c, input int taken, input int w);
        int top;
        top = (1 << w) - 1;
        if (taken != 0) return (c == top) ? top : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    function automatic int exp_idx_a();
        return a_spec ^ (int'(a_if.Fetch_PC >> 2) & ((1 << AH) - 1));
    endfunction

    function automatic int exp_pred_a();
        return (a_pht[exp_idx_a()] >= (1 << (AC - 1))) ? 1 : 0;
    endfunction

    function automatic int exp_idx_b();
        return b_spec;
    endfunction

    function automatic int exp_pred_b();
        return (b_pht[exp_idx_b()] >= (1 << (BC - 1))) ? 1 : 0;
    endfunction

    always @(posedge CLK or posedge rst_a) begin
        int ns;
        if (rst_a) begin
            foreach (a_pht[i]) a_pht[i] = (1 << (AC - 1)) - 1;
            a_spec = 0;
            a_arch = 0;
        end else begin
            ns = a_spec;
            if (a_if.Res_Valid && a_if.Res_Mispredict)
                ns = shift_in(a_arch, int'(a_if.Res_Taken), AH);
            else if (a_if.Fetch_Valid)
                ns = shift_in(a_spec, exp_pred_a(), AH);
            if (a_if.Res_Valid) begin
                a_arch = shift_in(a_arch, int'(a_if.Res_Taken), AH);
                a_pht[int'(a_if.Res_Idx)] = train(a_pht[int'(a_if.Res_Idx)], int'(a_if.Res_Taken), AC);
            end
            a_spec = ns;
        end
    end

    always @(posedge CLK or posedge rst_b) begin
        int ns;
        if (rst_b) begin
            foreach (b_pht[i]) b_pht[i] = (1 << (BC - 1)) - 1;
            b_spec = 0;
            b_arch = 0;
        end else begin
            ns = b_spec;
            if (b_if.Res_Valid && b_if.Res_Mispredict)
                ns = shift_in(b_arch, int'(b_if.Res_Taken), BH);
            else if (b_if.Fetch_Valid)
                ns = shift_in(b_spec, exp_pred_b(), BH);
            if (b_if.Res_Valid) begin
                b_arch = shift_in(b_arch, int'(b_if.Res_Taken), BH);
                b_pht[int'(b_if.Res_Idx)] = train(b_pht[int'(b_if.Res_Idx)], int'(b_if.Res_Taken), BC);
            end
            b_spec = ns;
        end
    end

    // Outputs are combinational and always meaningful, so compare every cycle.
    always @(negedge CLK) begin
        check("a_pred",      32'(a_if.Pred),      exp_pred_a());
        check("a_pred_idx",  32'(a_if.Pred_Idx),  exp_idx_a());
        check("a_spec_hist", 32'(a_if.Spec_Hist), a_spec);
        check("b_pred",      32'(b_if.Pred),      exp_pred_b());
        check("b_pred_idx",  32'(b_if.Pred_Idx),  exp_idx_b());
        check("b_spec_hist", 32'(b_if.Spec_Hist), b_spec);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic a_idle();
        a_if.Fetch_Valid    = 1'b0;
        a_if.Fetch_PC       = '0;
        a_if.Res_Valid      = 1'b0;
        a_if.Res_Taken      = 1'b0;
        a_if.Res_Idx        = '0;
        a_if.Res_Mispredict = 1'b0;
    endtask

    task automatic b_idle();
        b_if.Fetch_Valid    = 1'b0;
        b_if.Fetch_PC       = '0;
        b_if.Res_Valid      = 1'b0;
        b_if.Res_Taken      = 1'b0;
        b_if.Res_Idx        = '0;
        b_if.Res_Mispredict = 1'b0;
    endtask

    task automatic a_fetch(input logic [31:0] pc);
        a_if.Fetch_Valid = 1'b1;
        a_if.Fetch_PC    = pc;
    endtask

    task automatic a_res(input logic [AH-1:0] idx, input logic taken, input logic mis);
        a_if.Res_Valid      = 1'b1;
        a_if.Res_Idx        = idx;
        a_if.Res_Taken      = taken;
        a_if.Res_Mispredict = mis;
    endtask

    task automatic b_fetch(input logic [31:0] pc);
        b_if.Fetch_Valid = 1'b1;
        b_if.Fetch_PC    = pc;
    endtask

    task automatic b_res(input logic [BH-1:0] idx, input logic taken, input logic mis);
        b_if.Res_Valid      = 1'b1;
        b_if.Res_Idx        = idx;
        b_if.Res_Taken      = taken;
        b_if.Res_Mispredict = mis;
    endtask

    initial begin
        logic [AH-1:0] train_idx [5];
        train_idx = '{12'h000, 12'h800, 12'hC00, 12'hE00, 12'hF00};

        rst_a = 1'b1;
        rst_b = 1'b1;
        a_idle();
        b_idle();
        repeat (2) step();
        check("a_reset_spec", 32'(a_if.Spec_Hist), 32'h0);
        check("a_reset_pred", 32'(a_if.Pred), 32'h0);
        rst_a = 1'b0;

        // First fetch after reset: PC 0x40 -> index 0x010, weakly not-taken.
        a_fetch(32'h0000_0040);
        #1;
        check("a_first_idx",  32'(a_if.Pred_Idx), 32'h010);
        check("a_first_pred", 32'(a_if.Pred), 32'h0);
        step();
        a_idle();
        #1;
        check("a_first_spec", 32'(a_if.Spec_Hist), 32'h000);

        // Three taken resolutions saturate counter 0x010 at 3.
        for (int i = 0; i < 3; i++) begin
            a_res(12'h010, 1'b1, 1'b0);
            step();
        end
        a_idle();
        a_fetch(32'h0000_0040);
        #1;
        check("a_sat_hi_idx",  32'(a_if.Pred_Idx), 32'h010);
        check("a_sat_hi_pred", 32'(a_if.Pred), 32'h1);
        step();
        a_idle();
        #1;
        check("a_spec_after_taken_fetch", 32'(a_if.Spec_Hist), 32'h800);

        // Four not-taken resolutions: 3->2->1->0->0.
        for (int i = 0; i < 4; i++) begin
            a_res(12'h010, 1'b0, 1'b0);
            step();
        end
        a_idle();
        a_fetch(32'h0000_2040);
        #1;
        check("a_sat_lo_idx",  32'(a_if.Pred_Idx), 32'h010);
        check("a_sat_lo_pred", 32'(a_if.Pred), 32'h0);
        step();
        a_idle();

        // Fresh state; train the five indices the speculative path will visit.
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        foreach (train_idx[i]) begin
            a_res(train_idx[i], 1'b1, 1'b0);
            step();
        end
        for (int i = 0; i < 12; i++) begin
            a_res(12'h123, 1'b0, 1'b0);
            step();
        end
        a_idle();
        for (int i = 0; i < 5; i++) begin
            a_fetch(32'h0);
            #1;
            check("a_spec_walk_pred", 32'(a_if.Pred), 32'h1);
            step();
        end
        a_idle();
        #1;
        check("a_spec_five_taken", 32'(a_if.Spec_Hist), 32'hF80);

        a_res(12'h123, 1'b0, 1'b1);
        step();
        a_idle();
        #1;
        check("a_repair_spec", 32'(a_if.Spec_Hist), 32'h000);

        // Same-cycle fetch and mispredict: repair wins.
        for (int i = 0; i < 2; i++) begin
            a_res(12'h123, 1'b1, 1'b0);
            step();
        end
        a_idle();
        a_fetch(32'h0);
        a_res(12'h123, 1'b1, 1'b1);
        #1;
        check("a_squash_pred", 32'(a_if.Pred), 32'h1);
        step();
        a_idle();
        #1;
        check("a_squash_spec", 32'(a_if.Spec_Hist), 32'hE00);

        // Read/write collision on index 0x020 (counter 1).
        a_fetch(32'h0000_3880);
        a_res(12'h020, 1'b1, 1'b0);
        #1;
        check("a_coll_idx",  32'(a_if.Pred_Idx), 32'h020);
        check("a_coll_pred", 32'(a_if.Pred), 32'h0);
        step();
        a_idle();
        a_fetch(32'h0000_1C80);
        #1;
        check("a_coll_next_idx",  32'(a_if.Pred_Idx), 32'h020);
        check("a_coll_next_pred", 32'(a_if.Pred), 32'h1);
        step();
        a_idle();
        #1;
        check("a_coll_spec", 32'(a_if.Spec_Hist), 32'hB80);

        // History-only indexing, 3-bit counters reset to 3.
        rst_b = 1'b0;
        b_fetch(32'h0000_0ABC);
        #1;
        check("b_idx_ignores_pc", 32'(b_if.Pred_Idx), 32'h0);
        check("b_reset_pred",     32'(b_if.Pred), 32'h0);
        step();
        b_idle();
        b_res(4'h0, 1'b1, 1'b0);
        step();
        b_idle();
        b_fetch(32'h0000_1234);
        #1;
        check("b_one_inc_pred", 32'(b_if.Pred), 32'h1);
        step();
        b_idle();
        b_fetch(32'h0000_FFFF);
        #1;
        check("b_idx_is_hist", 32'(b_if.Pred_Idx), 32'h8);
        check("b_spec_hist",   32'(b_if.Spec_Hist), 32'h8);
        #1;
        rst_b = 1'b1;
        #1;
        check("b_async_spec", 32'(b_if.Spec_Hist), 32'h0);
        check("b_async_idx",  32'(b_if.Pred_Idx), 32'h0);
        check("b_async_pred", 32'(b_if.Pred), 32'h0);
        step();
        rst_b = 1'b0;
        b_idle();
        repeat (3) step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, limit 100000 time units");
        $fatal(1);
    end
endmodule
